// File: rtl/serial_xs3_bcd_codec_pkg.sv
// Shared constants and helpers for the serial Excess-3 / BCD codec.
package xs3_pkg;
    localparam logic [3:0] XS3_OFFSET      = 4'd3;
    localparam logic       MODE_XS3_TO_BCD = 1'b0;
    localparam logic       MODE_BCD_TO_XS3 = 1'b1;

    function automatic logic bcd_invalid(input logic [3:0] nibble);
        return nibble > 4'd9;
    endfunction
endpackage

// File: rtl/serial_xs3_bcd_codec_cell.sv
// One-bit serial add/subtract of the constant 3, LSB first, with the
// carry/borrow flop cleared at every digit boundary.
module xs3_serial_cell (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       en_i,
    input  logic       x_i,
    input  logic       sub_i,
    input  logic [1:0] pos_i,
    output logic       z_o,
    output logic       c_next_o
);
    logic c_q;
    logic k;

    // Constant 0011: k is set only on the two low bit positions of a digit.
    assign k = ~pos_i[1];

    always_comb begin
        z_o      = en_i ? (x_i ^ k ^ c_q) : 1'b0;
        c_next_o = sub_i ? ((~x_i & (k | c_q)) | (x_i & k & c_q))
                         : ((x_i & k) | (x_i & c_q) | (k & c_q));
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            c_q <= 1'b0;
        else if (en_i)
            c_q <= (pos_i == 2'd3) ? 1'b0 : c_next_o;
    end
endmodule

// File: rtl/serial_xs3_bcd_codec.sv
// Multi-digit serial XS3<->BCD codec: Mealy bit output plus a registered
// frame word with per-digit validity flags and a frame-done pulse.
module serial_xs3_bcd_codec
    import xs3_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   En,
    input  logic                   X,
    input  logic                   Mode,
    output logic                   Z,
    output logic [4*NDIGITS-1:0]   Q,
    output logic [NDIGITS-1:0]     DigitErr,
    output logic                   Err,
    output logic                   Done
);
    localparam int FB = 4 * NDIGITS;
    localparam int CW = $clog2(FB);

    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic               mode_q;
    logic [FB-1:0]      sr_q, sr_d;
    logic [NDIGITS-1:0] flags_q, flags_d;
    logic [1:0]         pos;
    logic               first, last, mode_eff, sub, c_next, dig_err;
    logic [3:0]         nib;

    assign pos      = bit_cnt_q[1:0];
    assign first    = (bit_cnt_q == '0);
    assign last     = (bit_cnt_q == CW'(FB - 1));
    assign mode_eff = first ? Mode : mode_q;
    assign sub      = (mode_eff == MODE_XS3_TO_BCD);

    xs3_serial_cell u_cell (
        .Clk      (Clk),
        .Rst      (Rst),
        .en_i     (En),
        .x_i      (X),
        .sub_i    (sub),
        .pos_i    (pos),
        .z_o      (Z),
        .c_next_o (c_next)
    );

    // Add-mode input is recovered from the output nibble (out - 3 mod 16).
    always_comb begin
        nib     = {Z, sr_q[FB-1 -: 3]};
        dig_err = sub ? (c_next | bcd_invalid(nib)) : bcd_invalid(nib - XS3_OFFSET);
        sr_d    = {Z, sr_q[FB-1:1]};
        bit_cnt_d = last ? '0 : bit_cnt_q + CW'(1);
        flags_d = flags_q;
        for (int k = 0; k < NDIGITS; k++)
            if (pos == 2'd3 && (bit_cnt_q >> 2) == CW'(k))
                flags_d[k] = dig_err;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt_q <= '0;
            mode_q    <= 1'b0;
            sr_q      <= '0;
            flags_q   <= '0;
            Q         <= '0;
            DigitErr  <= '0;
            Err       <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= En && last;
            if (En) begin
                bit_cnt_q <= bit_cnt_d;
                sr_q      <= sr_d;
                flags_q   <= flags_d;
                if (first)
                    mode_q <= Mode;
                if (last) begin
                    Q        <= sr_d;
                    DigitErr <= flags_d;
                    Err      <= |flags_d;
                end
            end
        end
    end
endmodule
